// File: rtl/mem_wb_pipe.sv
// MEM->WB write-back pipeline: NUM_CH write channels delayed by DEPTH register stages,
// with flush/hold/bubble control, youngest-first forwarding and a saturating bubble counter.
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          mem_we,
    input  logic [NUM_CH*ADDR_W-1:0]   mem_waddr,
    input  logic [NUM_CH*DATA_W-1:0]   mem_wdata,
    input  logic                       stall_in,
    input  logic                       stall_out,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          fwd_raddr,
    output logic [NUM_CH-1:0]          wb_we,
    output logic [NUM_CH*ADDR_W-1:0]   wb_waddr,
    output logic [NUM_CH*DATA_W-1:0]   wb_wdata,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [15:0]                bubble_cnt
);

    logic [NUM_CH-1:0]        we_p   [DEPTH];
    logic [NUM_CH*ADDR_W-1:0] addr_p [DEPTH];
    logic [NUM_CH*DATA_W-1:0] data_p [DEPTH];
    logic [NUM_CH-1:0]        san_we;

    // Writes to register 0 are dropped; on an address collision the higher channel wins.
    function automatic logic [NUM_CH-1:0] sanitise_we(
        input logic [NUM_CH-1:0]        we,
        input logic [NUM_CH*ADDR_W-1:0] addr
    );
        logic [NUM_CH-1:0] keep;
        keep = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            keep[c] = we[c] && (addr[c*ADDR_W +: ADDR_W] != '0);
            for (int h = c + 1; h < NUM_CH; h++) begin
                if (we[h] && (addr[h*ADDR_W +: ADDR_W] == addr[c*ADDR_W +: ADDR_W]))
                    keep[c] = 1'b0;
            end
        end
        return keep;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb san_we = sanitise_we(mem_we, mem_waddr);

    // Stage 0 takes sanitised MEM inputs (or a bubble); stage k takes stage k-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                we_p[k]   <= '0;
                addr_p[k] <= '0;
                data_p[k] <= '0;
            end
            bubble_cnt <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                we_p[k]   <= '0;
                addr_p[k] <= '0;
                data_p[k] <= '0;
            end
        end else if (!stall_out) begin
            if (stall_in) begin
                we_p[0]    <= '0;
                addr_p[0]  <= '0;
                data_p[0]  <= '0;
                bubble_cnt <= sat_inc(bubble_cnt);
            end else begin
                we_p[0]   <= san_we;
                addr_p[0] <= mem_waddr;
                data_p[0] <= mem_wdata;
            end
            for (int k = 1; k < DEPTH; k++) begin
                we_p[k]   <= we_p[k-1];
                addr_p[k] <= addr_p[k-1];
                data_p[k] <= data_p[k-1];
            end
        end
    end

    assign wb_we    = we_p[DEPTH-1];
    assign wb_waddr = addr_p[DEPTH-1];
    assign wb_wdata = data_p[DEPTH-1];

    // Youngest stage first, highest channel first within a stage.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_raddr != '0) begin
            for (int s = 0; s < DEPTH; s++) begin
                for (int c = NUM_CH - 1; c >= 0; c--) begin
                    if (!fwd_hit && we_p[s][c] &&
                        (addr_p[s][c*ADDR_W +: ADDR_W] == fwd_raddr)) begin
                        fwd_hit  = 1'b1;
                        fwd_data = data_p[s][c*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: DEPTH=1 and DEPTH=3 instances driven in parallel, hand vectors,
// multi-cycle sequences and random traffic checked against a queue-style reference model.
module tb_mem_wb_pipe;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NC = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NC-1:0]    mem_we;
    logic [NC*AW-1:0] mem_waddr;
    logic [NC*DW-1:0] mem_wdata;
    logic stall_in, stall_out, flush;
    logic [AW-1:0]    fwd_raddr;

    logic [NC-1:0] w1_we, w3_we;
    logic [NC*AW-1:0] w1_a, w3_a;
    logic [NC*DW-1:0] w1_d, w3_d;
    logic h1, h3;
    logic [DW-1:0] f1, f3;
    logic [15:0] c1, c3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .stall_in(stall_in), .stall_out(stall_out), .flush(flush), .fwd_raddr(fwd_raddr),
        .wb_we(w1_we), .wb_waddr(w1_a), .wb_wdata(w1_d), .fwd_hit(h1), .fwd_data(f1),
        .bubble_cnt(c1));

    mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .DEPTH(3)) u3 (
        .clk(clk), .rst(rst), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .stall_in(stall_in), .stall_out(stall_out), .flush(flush), .fwd_raddr(fwd_raddr),
        .wb_we(w3_we), .wb_waddr(w3_a), .wb_wdata(w3_d), .fwd_hit(h3), .fwd_data(f3),
        .bubble_cnt(c3));

    typedef struct packed {
        logic [NC-1:0]    we;
        logic [NC*AW-1:0] a;
        logic [NC*DW-1:0] d;
    } ent_t;

    // Reference: index 0 models the DEPTH=1 pipe, index 1 the DEPTH=3 pipe; slot 0 is youngest.
    ent_t ms [2][4];
    logic [15:0] mcnt;

    function automatic int depth_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic ent_t sanitise(input logic [NC-1:0] we, input logic [NC*AW-1:0] a,
                                      input logic [NC*DW-1:0] d);
        ent_t r;
        logic [31:0] taken;
        logic [AW-1:0] ad;
        taken = '0;
        r.we = '0;
        r.a = a;
        r.d = d;
        for (int c = NC - 1; c >= 0; c--) begin
            ad = a[c*AW +: AW];
            if (we[c] && ad != 0 && !taken[ad]) r.we[c] = 1'b1;
            if (we[c]) taken[ad] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) ms[i][k] = '0;
        mcnt = 16'd0;
    endtask

    task automatic model_step();
        ent_t nw;
        if (flush) begin
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 4; k++) ms[i][k] = '0;
        end else if (!stall_out) begin
            nw = stall_in ? ent_t'('0) : sanitise(mem_we, mem_waddr, mem_wdata);
            for (int i = 0; i < 2; i++) begin
                for (int k = depth_of(i) - 1; k > 0; k--) ms[i][k] = ms[i][k-1];
                ms[i][0] = nw;
            end
            if (stall_in && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
        end
    endtask

    task automatic fwd_model(input int i, output logic hit, output logic [DW-1:0] data);
        hit = 1'b0;
        data = '0;
        if (fwd_raddr != 0)
            for (int k = 0; k < depth_of(i); k++)
                for (int c = NC - 1; c >= 0; c--)
                    if (!hit && ms[i][k].we[c] && ms[i][k].a[c*AW +: AW] == fwd_raddr) begin
                        hit = 1'b1;
                        data = ms[i][k].d[c*DW +: DW];
                    end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all();
        logic hit;
        logic [DW-1:0] fd;
        chk("u1_we",   64'(w1_we), 64'(ms[0][0].we));
        chk("u1_addr", 64'(w1_a),  64'(ms[0][0].a));
        chk("u1_data", 64'(w1_d),  64'(ms[0][0].d));
        chk("u3_we",   64'(w3_we), 64'(ms[1][2].we));
        chk("u3_addr", 64'(w3_a),  64'(ms[1][2].a));
        chk("u3_data", 64'(w3_d),  64'(ms[1][2].d));
        fwd_model(0, hit, fd);
        chk("u1_hit",  64'(h1), 64'(hit));
        chk("u1_fwd",  64'(f1), 64'(fd));
        fwd_model(1, hit, fd);
        chk("u3_hit",  64'(h3), 64'(hit));
        chk("u3_fwd",  64'(f3), 64'(fd));
        chk("u1_cnt",  64'(c1), 64'(mcnt));
        chk("u3_cnt",  64'(c3), 64'(mcnt));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic [NC-1:0] we, input logic [NC*AW-1:0] a,
                         input logic [NC*DW-1:0] d, input logic si, input logic so,
                         input logic fl, input logic [AW-1:0] ra);
        mem_we = we; mem_waddr = a; mem_wdata = d;
        stall_in = si; stall_out = so; flush = fl; fwd_raddr = ra;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_u1_we"}, 64'(w1_we), 64'd0);
        chk({tag, "_u1_d"},  64'(w1_d),  64'd0);
        chk({tag, "_u3_we"}, 64'(w3_we), 64'd0);
        chk({tag, "_u3_a"},  64'(w3_a),  64'd0);
        chk({tag, "_u3_d"},  64'(w3_d),  64'd0);
        chk({tag, "_u3_hit"}, 64'(h3), 64'd0);
        chk({tag, "_cnt"},   64'(c3), 64'd0);
    endtask

    typedef struct packed {
        logic [NC-1:0]    we;
        logic [NC*AW-1:0] a;
        logic [NC*DW-1:0] d;
        logic si, so, fl;
        logic [AW-1:0]    ra;
        logic [NC-1:0]    xwe;
        logic [NC*AW-1:0] xa;
        logic [NC*DW-1:0] xd;
        logic             xhit;
        logic [DW-1:0]    xfd;
        logic [15:0]      xcnt;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // Expected DEPTH=1 outputs one edge after each row's inputs.
        tbl[0]  = '{2'b11, {5'd4, 5'd3}, {32'hBB, 32'hAA}, 1'b0, 1'b0, 1'b0, 5'd4,
                    2'b11, {5'd4, 5'd3}, {32'hBB, 32'hAA}, 1'b1, 32'hBB, 16'd0};
        tbl[1]  = '{2'b11, {5'd7, 5'd7}, {32'h22, 32'h11}, 1'b0, 1'b0, 1'b0, 5'd7,
                    2'b10, {5'd7, 5'd7}, {32'h22, 32'h11}, 1'b1, 32'h22, 16'd0};
        tbl[2]  = '{2'b01, {5'd9, 5'd0}, {32'h66, 32'h55}, 1'b0, 1'b0, 1'b0, 5'd0,
                    2'b00, {5'd9, 5'd0}, {32'h66, 32'h55}, 1'b0, 32'h0, 16'd0};
        tbl[3]  = '{2'b11, {5'd2, 5'd1}, {32'h2, 32'h1}, 1'b1, 1'b0, 1'b0, 5'd1,
                    2'b00, 10'd0, 64'd0, 1'b0, 32'h0, 16'd1};
        tbl[4]  = '{2'b11, {5'd2, 5'd1}, {32'h2, 32'h1}, 1'b1, 1'b0, 1'b0, 5'd1,
                    2'b00, 10'd0, 64'd0, 1'b0, 32'h0, 16'd2};
        tbl[5]  = '{2'b11, {5'd2, 5'd1}, {32'h2, 32'h1}, 1'b1, 1'b0, 1'b0, 5'd1,
                    2'b00, 10'd0, 64'd0, 1'b0, 32'h0, 16'd3};
        tbl[6]  = '{2'b11, {5'd2, 5'd1}, {32'h2, 32'h1}, 1'b0, 1'b0, 1'b0, 5'd2,
                    2'b11, {5'd2, 5'd1}, {32'h2, 32'h1}, 1'b1, 32'h2, 16'd3};
        tbl[7]  = '{2'b11, {5'd6, 5'd5}, {32'h6, 32'h5}, 1'b1, 1'b1, 1'b0, 5'd1,
                    2'b11, {5'd2, 5'd1}, {32'h2, 32'h1}, 1'b1, 32'h1, 16'd3};
        tbl[8]  = '{2'b11, {5'd6, 5'd5}, {32'h6, 32'h5}, 1'b0, 1'b1, 1'b0, 5'd5,
                    2'b11, {5'd2, 5'd1}, {32'h2, 32'h1}, 1'b0, 32'h0, 16'd3};
        tbl[9]  = '{2'b11, {5'd6, 5'd5}, {32'h6, 32'h5}, 1'b0, 1'b1, 1'b1, 5'd2,
                    2'b00, 10'd0, 64'd0, 1'b0, 32'h0, 16'd3};
        tbl[10] = '{2'b11, {5'd6, 5'd5}, {32'h6, 32'h5}, 1'b1, 1'b0, 1'b1, 5'd2,
                    2'b00, 10'd0, 64'd0, 1'b0, 32'h0, 16'd3};

        rst = 1'b0;
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        model_reset();
        #2;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].si, tbl[i].so, tbl[i].fl, tbl[i].ra);
            cycle();
            chk($sformatf("vec%0d_we", i),   64'(w1_we), 64'(tbl[i].xwe));
            chk($sformatf("vec%0d_addr", i), 64'(w1_a),  64'(tbl[i].xa));
            chk($sformatf("vec%0d_data", i), 64'(w1_d),  64'(tbl[i].xd));
            chk($sformatf("vec%0d_hit", i),  64'(h1),    64'(tbl[i].xhit));
            chk($sformatf("vec%0d_fwd", i),  64'(f1),    64'(tbl[i].xfd));
            chk($sformatf("vec%0d_cnt", i),  64'(c1),    64'(tbl[i].xcnt));
        end

        // Same address written twice in a row through the 3-deep pipe.
        drive(2'b01, {5'd0, 5'd5}, {32'h0, 32'h1}, 1'b0, 1'b0, 1'b0, 5'd5);
        cycle();
        chk("d3_fwd_first", 64'(f3), 64'd1);
        mem_wdata = {32'h0, 32'h2};
        cycle();
        chk("d3_fwd_young_hit", 64'(h3), 64'd1);
        chk("d3_fwd_young", 64'(f3), 64'd2);
        mem_we = 2'b00;
        cycle();
        chk("d3_wb1_we", 64'(w3_we), 64'd1);
        chk("d3_wb1_addr", 64'(w3_a[AW-1:0]), 64'd5);
        chk("d3_wb1_data", 64'(w3_d[DW-1:0]), 64'd1);
        chk("d3_fwd_after", 64'(f3), 64'd2);
        cycle();
        chk("d3_wb2_we", 64'(w3_we), 64'd1);
        chk("d3_wb2_data", 64'(w3_d[DW-1:0]), 64'd2);

        // Flush while downstream is stalled and every stage holds a valid write.
        drive(2'b11, {5'd3, 5'd2}, {32'h33, 32'h22}, 1'b0, 1'b0, 1'b0, 5'd3);
        repeat (3) cycle();
        chk("full_we", 64'(w3_we), 64'd3);
        chk("full_hit", 64'(h3), 64'd1);
        drive(2'b11, {5'd3, 5'd2}, {32'h44, 32'h55}, 1'b0, 1'b1, 1'b1, 5'd3);
        cycle();
        chk("flush_u3_we", 64'(w3_we), 64'd0);
        chk("flush_u1_we", 64'(w1_we), 64'd0);
        chk("flush_hit", 64'(h3), 64'd0);
        chk("flush_cnt", 64'(c3), 64'd3);

        // Reset asserted between edges overrides held data, stalls and flush.
        drive(2'b11, {5'd9, 5'd8}, {32'h99, 32'h88}, 1'b0, 1'b0, 1'b0, 5'd9);
        repeat (2) cycle();
        chk("pre_rst_hit", 64'(h3), 64'd1);
        #3;
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        drive(2'b11, {5'd9, 5'd8}, {32'h99, 32'h88}, 1'b1, 1'b1, 1'b1, 5'd9);
        @(posedge clk);
        #1;
        check_zero("rst_held");
        rst = 1'b1;
        drive(2'b11, {5'd9, 5'd8}, {32'h99, 32'h88}, 1'b0, 1'b0, 1'b0, 5'd9);
        cycle();
        chk("post_rst_u1_we", 64'(w1_we), 64'd3);
        chk("post_rst_u1_d", 64'(w1_d), {32'h99, 32'h88});

        // Bubble counter saturation.
        drive(2'b11, {5'd1, 5'd2}, {32'h1, 32'h2}, 1'b1, 1'b0, 1'b0, 5'd1);
        repeat (65534) begin
            @(posedge clk);
            model_step();
        end
        #1;
        chk("sat_fffe", 64'(c1), 64'hFFFE);
        cycle();
        chk("sat_ffff", 64'(c3), 64'hFFFF);
        repeat (5) begin
            @(posedge clk);
            model_step();
        end
        #1;
        chk("sat_hold", 64'(c1), 64'hFFFF);
        flush = 1'b1;
        cycle();
        chk("sat_flush", 64'(c3), 64'hFFFF);

        // Random traffic with a narrow address range to provoke collisions and hits.
        for (int n = 0; n < 1500; n++) begin
            drive(2'($urandom), {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                  {$urandom, $urandom}, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 30) == 0),
                  5'($urandom_range(0, 7)));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, write-data width per channel.
REQ-002 SHALL have parameter ADDR_W, default 5, register-address width.
REQ-003 SHALL have parameter NUM_CH, default 2, number of independent write-back channels (1..4).
REQ-004 SHALL have parameter DEPTH, default 1, number of register stages between MEM and WB (1..4).
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port mem_we  input  NUM_CH  per-channel write enable from MEM.
REQ-008 SHALL have port mem_waddr  input  NUM_CH*ADDR_W  packed addresses, channel c at bits [c*ADDR_W +: ADDR_W].
REQ-009 SHALL have port mem_wdata  input  NUM_CH*DATA_W  packed data, same packing.
REQ-010 SHALL have port stall_in  input  1  this stage stalled (MEM side).
REQ-011 SHALL have port stall_out  input  1  downstream (WB) stalled.
REQ-012 SHALL have port flush  input  1  synchronous clear of all stages.
REQ-013 SHALL have port fwd_raddr  input  ADDR_W  forwarding lookup address.
REQ-014 SHALL have port wb_we / wb_waddr / wb_wdata  output  NUM_CH / NUM_CH*ADDR_W / NUM_CH*DATA_W  last-stage contents.
REQ-015 SHALL have port fwd_hit  output  1  and fwd_data  output  DATA_W  forwarding result.
REQ-016 SHALL have port bubble_cnt  output  16  count of inserted bubbles.

Function
REQ-017 Stage 0 SHALL capture sanitised inputs; stage k SHALL capture stage k-1; wb_* SHALL be stage DEPTH-1; latency DEPTH cycles.
REQ-018 Sanitise: channel with waddr==0 SHALL have we forced 0; waddr/wdata stored unchanged.
REQ-019 Sanitise: if two enabled channels share an address, the higher-index channel SHALL win; lower ones get we=0.
REQ-020 Priority per edge: flush > hold > bubble > advance.
REQ-021 flush=1: all stages SHALL load we=0, addr=0, data=0, regardless of stalls.
REQ-022 Hold (stall_out=1, any stall_in): all stages SHALL keep their value; stall_out with stall_in=0 treated as hold.
REQ-023 Bubble (stall_in=1, stall_out=0): stage 0 SHALL load we=0, addr=0, data=0; stages 1..DEPTH-1 advance; bubble_cnt increments.
REQ-024 Advance (stall_in=0, stall_out=0): all stages shift, stage 0 loads sanitised inputs.
REQ-025 bubble_cnt SHALL saturate at 0xFFFF; flush SHALL NOT clear it; increments only in bubble case.
REQ-026 Forwarding SHALL be combinational from stage registers: search stage 0 first (youngest), within a stage highest channel first; first entry with we=1 and addr==fwd_raddr wins.
REQ-027 fwd_raddr==0 or no match: fwd_hit=0, fwd_data=0.
REQ-028 Inputs SHALL have no combinational path to wb_* or bubble_cnt.

Reset
REQ-029 rst=0 SHALL immediately, without clock, set all stages to we=0, addr=0, data=0, bubble_cnt=0; wb_* and fwd_hit therefore 0.
REQ-030 Reset asserted mid-stall or mid-flush SHALL override; first edge after rst release SHALL follow REQ-020 normally.

Verification
REQ-031 DEPTH=1, NUM_CH=2: ch0 we=1 addr=3 data=0xAA, ch1 we=1 addr=4 data=0xBB, no stall -> next cycle wb shows both, we=2'b11.
REQ-032 Collision: ch0 and ch1 both we=1 addr=7, data 0x11/0x22 -> wb_we=2'b10, fwd_raddr=7 gives hit=1 data=0x22; addr=0 write -> we=0.
REQ-033 stall_in=1, stall_out=0 for 3 cycles -> wb_we=0 for 3 cycles, bubble_cnt=3; then stall_in=stall_out=1 -> wb_* held, bubble_cnt unchanged.
REQ-034 DEPTH=3: write addr=5 data=1 then addr=5 data=2 next cycle -> fwd_data=2 (youngest); after 3 advances wb shows data=1 then 2.
REQ-035 flush during stall_out=1 with all stages valid -> next edge all we=0; bubble_cnt preserved.
REQ-036 Drive rst=0 between clock edges with valid data held -> outputs 0 before next edge; bubble_cnt preloaded to 0xFFFF-equivalent saturation check: 65540 bubbles -> 0xFFFF.
